// File: rtl/spad_req_arbiter.sv
// Arbitrates MLS and GEMM requests into one scratchpad FIFO word stream.
// Optional perf counters: define SPAD_ARB_PERF_EN.
module spad_req_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int MAT_W           = 4,
  parameter int STRIDE_W        = 5,
  parameter int MAX_OUTSTANDING = 4,
  localparam int WDATA_W = 2 + MAT_W + ADDR_W + STRIDE_W,
  localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                mls_valid,
  output logic                mls_ready,
  input  logic                mls_is_store,
  input  logic [MAT_W-1:0]    mls_rd,
  input  logic [ADDR_W-1:0]   mls_addr,
  input  logic [STRIDE_W-1:0] mls_stride,
  input  logic                gemm_valid,
  output logic                gemm_ready,
  input  logic                gemm_new_weight,
  input  logic [MAT_W-1:0]    gemm_rs1,
  input  logic [MAT_W-1:0]    gemm_rs2,
  input  logic [MAT_W-1:0]    gemm_rs3,
  input  logic [MAT_W-1:0]    gemm_rd,
  input  logic                fifo_full,
  output logic                fifo_wen,
  output logic [WDATA_W-1:0]  fifo_wdata,
  input  logic                spad_done,
  output logic [CNT_W-1:0]    outstanding,
  output logic                busy
`ifdef SPAD_ARB_PERF_EN
  ,
  output logic [31:0]         perf_full_stall,
  output logic [31:0]         perf_credit_stall,
  output logic [31:0]         perf_conflict
`endif
);

  localparam int PAD_W = ADDR_W - 4 * MAT_W;

  logic               r_out_valid;
  logic [WDATA_W-1:0] r_word;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rr;

  logic               w_done;
  logic [CNT_W:0]     w_committed;
  logic               w_credit_ok;
  logic               w_slot_open;
  logic               w_slot_free;
  logic               w_grant_m;
  logic               w_grant_g;
  logic [1:0]         w_mls_op;
  logic [WDATA_W-1:0] w_mls_word;
  logic [WDATA_W-1:0] w_gemm_word;
  logic [WDATA_W-1:0] w_next_word;

  assign fifo_wen    = r_out_valid & ~fifo_full;
  assign fifo_wdata  = r_word;
  assign outstanding = r_cnt;
  assign busy        = r_out_valid | (r_cnt != '0);

  // A completion this cycle frees a credit for this cycle's grant.
  assign w_done      = spad_done & (r_cnt != '0);
  assign w_committed = {1'b0, r_cnt}
                     + (CNT_W+1)'(r_out_valid)
                     - (CNT_W+1)'(w_done);
  assign w_credit_ok = w_committed < (CNT_W+1)'(MAX_OUTSTANDING);
  assign w_slot_open = ~r_out_valid | fifo_wen;
  assign w_slot_free = w_slot_open & w_credit_ok;

  assign w_grant_m = nRST & w_slot_free & mls_valid
                   & (~gemm_valid | ~r_rr);
  assign w_grant_g = nRST & w_slot_free & gemm_valid
                   & (~mls_valid | r_rr);

  assign mls_ready  = w_grant_m;
  assign gemm_ready = w_grant_g;

  assign w_mls_op   = mls_is_store ? 2'b10 : 2'b01;
  assign w_mls_word = {w_mls_op, mls_rd,
                       mls_addr, mls_stride};
  assign w_gemm_word = {2'b11, gemm_new_weight,
                        {(MAT_W-1){1'b0}},
                        {PAD_W{1'b0}},
                        gemm_rs1, gemm_rs2,
                        gemm_rs3, gemm_rd,
                        {STRIDE_W{1'b0}}};

  always_comb begin
    w_next_word = w_mls_word;
    unique case (1'b1)
      w_grant_g: w_next_word = w_gemm_word;
      default:   w_next_word = w_mls_word;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_out_valid <= 1'b0;
      r_word      <= '0;
      r_cnt       <= '0;
      r_rr        <= 1'b0;
    end else begin
      if (w_grant_m | w_grant_g) begin
        r_out_valid <= 1'b1;
        r_word      <= w_next_word;
        r_rr        <= w_grant_m;
      end else if (fifo_wen) begin
        r_out_valid <= 1'b0;
      end
      r_cnt <= r_cnt + CNT_W'(fifo_wen)
                     - CNT_W'(w_done);
    end
  end

`ifdef SPAD_ARB_PERF_EN
  logic [31:0] r_perf_full;
  logic [31:0] r_perf_credit;
  logic [31:0] r_perf_conf;
  logic        w_req;

  assign w_req = mls_valid | gemm_valid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_perf_full   <= '0;
      r_perf_credit <= '0;
      r_perf_conf   <= '0;
    end else begin
      if (r_out_valid & fifo_full)
        r_perf_full <= r_perf_full + 32'd1;
      if (w_req & w_slot_open & ~w_credit_ok)
        r_perf_credit <= r_perf_credit + 32'd1;
      if (mls_valid & gemm_valid)
        r_perf_conf <= r_perf_conf + 32'd1;
    end
  end

  assign perf_full_stall   = r_perf_full;
  assign perf_credit_stall = r_perf_credit;
  assign perf_conflict     = r_perf_conf;
`endif

endmodule

// File: tb/tb_spad_req_arbiter.sv
// Directed + random bench for spad_req_arbiter
// against a queue-style reference model.
module tb_spad_req_arbiter;
  localparam int MAXO = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        mls_valid, mls_ready, mls_is_store;
  logic [3:0]  mls_rd;
  logic [31:0] mls_addr;
  logic [4:0]  mls_stride;
  logic        gemm_valid, gemm_ready, gemm_new_weight;
  logic [3:0]  gemm_rs1, gemm_rs2, gemm_rs3, gemm_rd;
  logic        fifo_full, fifo_wen;
  logic [42:0] fifo_wdata;
  logic        spad_done;
  logic [2:0]  outstanding;
  logic        busy;

  spad_req_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .mls_valid(mls_valid), .mls_ready(mls_ready),
    .mls_is_store(mls_is_store), .mls_rd(mls_rd),
    .mls_addr(mls_addr), .mls_stride(mls_stride),
    .gemm_valid(gemm_valid), .gemm_ready(gemm_ready),
    .gemm_new_weight(gemm_new_weight),
    .gemm_rs1(gemm_rs1), .gemm_rs2(gemm_rs2),
    .gemm_rs3(gemm_rs3), .gemm_rd(gemm_rd),
    .fifo_full(fifo_full), .fifo_wen(fifo_wen),
    .fifo_wdata(fifo_wdata), .spad_done(spad_done),
    .outstanding(outstanding), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int pushes = 0;

  // Reference: one pending word slot, in-flight count, preferred side.
  bit          m_pv;
  logic [42:0] m_word;
  int          m_inf;
  int          m_pref;
  bit          m_gm, m_gg;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pv = 0; m_word = '0; m_inf = 0; m_pref = 0;
    m_gm = 0; m_gg = 0;
  endtask

  function automatic logic [42:0] mls_word();
    logic [1:0] op;
    op = mls_is_store ? 2'b10 : 2'b01;
    return {op, mls_rd, mls_addr, mls_stride};
  endfunction

  function automatic logic [42:0] gemm_word();
    logic [3:0] hi;
    hi = {gemm_new_weight, 3'b000};
    return {2'b11, hi, 16'd0, gemm_rs1, gemm_rs2,
            gemm_rs3, gemm_rd, 5'd0};
  endfunction

  task automatic step();
    bit wen, de, free;
    int sel;
    @(negedge CLK);
    wen  = m_pv && !fifo_full;
    de   = spad_done && (m_inf > 0);
    free = (!m_pv || wen)
        && (m_inf + int'(m_pv) - int'(de) < MAXO);
    sel = -1;
    if (free) begin
      if (mls_valid && gemm_valid) sel = m_pref;
      else if (mls_valid)          sel = 0;
      else if (gemm_valid)         sel = 1;
    end
    chk("mls_ready", 64'(mls_ready), 64'(sel == 0));
    chk("gemm_ready", 64'(gemm_ready), 64'(sel == 1));
    chk("fifo_wen", 64'(fifo_wen), 64'(wen));
    chk("fifo_wdata", 64'(fifo_wdata), 64'(m_word));
    chk("outstanding", 64'(outstanding), 64'(m_inf));
    chk("busy", 64'(busy), 64'(m_pv || m_inf != 0));
    pushes += int'(fifo_wen);
    m_inf = m_inf + int'(wen) - int'(de);
    if (sel >= 0) begin
      m_pv   = 1;
      m_word = (sel == 1) ? gemm_word() : mls_word();
      m_pref = 1 - sel;
    end else if (wen) begin
      m_pv = 0;
    end
    m_gm = (sel == 0);
    m_gg = (sel == 1);
    @(posedge CLK); #1;
  endtask

  task automatic drain(input int n);
    spad_done = 1;
    repeat (n) step();
    spad_done = 0;
  endtask

  initial begin
    logic [42:0] exp_w;
    int base;
    nRST = 1;
    mls_valid = 0; mls_is_store = 0; mls_rd = 0;
    mls_addr = 0; mls_stride = 0;
    gemm_valid = 0; gemm_new_weight = 0;
    gemm_rs1 = 0; gemm_rs2 = 0; gemm_rs3 = 0; gemm_rd = 0;
    fifo_full = 0; spad_done = 0;
    model_reset();
    #1 nRST = 0;
    #2;
    chk("rst_wen", 64'(fifo_wen), 64'd0);
    chk("rst_wdata", 64'(fifo_wdata), 64'd0);
    chk("rst_outst", 64'(outstanding), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    mls_valid = 1; gemm_valid = 1;
    #1;
    chk("rst_mready", 64'(mls_ready), 64'd0);
    chk("rst_gready", 64'(gemm_ready), 64'd0);
    mls_valid = 0; gemm_valid = 0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1;
    #1;

    // Single MLS load
    mls_valid = 1; mls_rd = 4'd3;
    mls_addr = 32'h0000_1000; mls_stride = 5'd4;
    #1 chk("t1_ready", 64'(mls_ready), 64'd1);
    step();
    mls_valid = 0;
    exp_w = {2'b01, 4'd3, 32'h1000, 5'd4};
    #1;
    chk("t1_wen", 64'(fifo_wen), 64'd1);
    chk("t1_word", 64'(fifo_wdata), 64'(exp_w));
    step();
    chk("t1_outst", 64'(outstanding), 64'd1);
    drain(1);

    // Single GEMM
    gemm_valid = 1; gemm_new_weight = 1;
    gemm_rs1 = 1; gemm_rs2 = 2; gemm_rs3 = 3; gemm_rd = 4;
    step();
    gemm_valid = 0;
    exp_w = {2'b11, 4'b1000, 16'd0, 16'h1234, 5'd0};
    #1 chk("t2_word", 64'(fifo_wdata), 64'(exp_w));
    step();
    drain(1);

    // Continuous contention with completions every cycle
    mls_valid = 1; gemm_valid = 1; spad_done = 1;
    base = pushes;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t3_alt_m", 64'(mls_ready), 64'(i % 2 == 0));
      chk("t3_alt_g", 64'(gemm_ready), 64'(i % 2 == 1));
      step();
    end
    mls_valid = 0; gemm_valid = 0;
    step();
    chk("t3_pushes", 64'(pushes - base), 64'd6);
    chk("t3_outst", 64'(outstanding), 64'd1);
    step();
    spad_done = 0;

    // Credit exhaustion
    mls_valid = 1; mls_addr = 32'h2000;
    base = pushes;
    repeat (8) step();
    chk("t4_pushes", 64'(pushes - base), 64'd4);
    chk("t4_blocked", 64'(mls_ready), 64'd0);
    spad_done = 1;
    #1 chk("t4_credit", 64'(mls_ready), 64'd1);
    step();
    spad_done = 0;
    #1 chk("t4_push5", 64'(fifo_wen), 64'd1);
    step();
    chk("t4_reblock", 64'(mls_ready), 64'd0);
    mls_valid = 0;
    drain(5);

    // FIFO full stall
    mls_valid = 1; mls_is_store = 1;
    mls_rd = 4'd7; mls_addr = 32'hCAFE_0040; mls_stride = 5'd9;
    step();
    mls_valid = 0; fifo_full = 1;
    exp_w = {2'b10, 4'd7, 32'hCAFE_0040, 5'd9};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_nowen", 64'(fifo_wen), 64'd0);
      chk("t5_stable", 64'(fifo_wdata), 64'(exp_w));
      step();
    end
    fifo_full = 0;
    mls_valid = 1; mls_addr = 32'hCAFE_0080;
    #1;
    chk("t5_push", 64'(fifo_wen), 64'd1);
    chk("t5_regrant", 64'(mls_ready), 64'd1);
    step();
    mls_valid = 0; mls_is_store = 0;
    step();
    drain(3);

    // Asynchronous reset mid-operation
    mls_valid = 1;
    repeat (3) step();
    mls_valid = 0; fifo_full = 1;
    step();
    chk("t6_pre_outst", 64'(outstanding), 64'd2);
    #1 nRST = 0;
    #1;
    chk("t6_wen", 64'(fifo_wen), 64'd0);
    chk("t6_outst", 64'(outstanding), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    model_reset();
    fifo_full = 0;
    @(posedge CLK);
    #1 nRST = 1;
    mls_valid = 1; gemm_valid = 1;
    #1;
    chk("t6_first_m", 64'(mls_ready), 64'd1);
    chk("t6_first_g", 64'(gemm_ready), 64'd0);
    step();
    mls_valid = 0;
    step();
    gemm_valid = 0;
    step();
    drain(3);

    // Random traffic; requests hold until accepted
    for (int i = 0; i < 400; i++) begin
      if (!mls_valid || m_gm) begin
        mls_valid    = ($urandom % 10) < 6;
        mls_is_store = $urandom % 2;
        mls_rd       = 4'($urandom);
        mls_addr     = $urandom;
        mls_stride   = 5'($urandom);
      end
      if (!gemm_valid || m_gg) begin
        gemm_valid      = ($urandom % 10) < 6;
        gemm_new_weight = $urandom % 2;
        gemm_rs1 = 4'($urandom);
        gemm_rs2 = 4'($urandom);
        gemm_rs3 = 4'($urandom);
        gemm_rd  = 4'($urandom);
      end
      fifo_full = ($urandom % 4) == 0;
      spad_done = ($urandom % 3) == 0;
      step();
    end
    mls_valid = 0; gemm_valid = 0; fifo_full = 0;
    drain(6);
    chk("end_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
